fir_pipelined: RTL and testbench
================================

FIR_PIPELINED -- requirements
Module: fir_pipelined

Interface
REQ-001 SHALL: parameter TAPS, default 8, number of taps; a power of two, 2..32.
REQ-002 SHALL: parameter DATA_W, default 8, signed sample width.
REQ-003 SHALL: parameter COEF_W, default 8, signed coefficient width.
REQ-004 SHALL: parameter OUT_W, default 16, signed output width.
REQ-005 SHALL: parameter OUT_SHIFT, default 0, arithmetic right shift applied before saturation; range 0..(DATA_W+COEF_W+log2(TAPS)-1).
REQ-006 SHALL: one clock; reset is synchronous and active-high.
REQ-007 SHALL: clk  input  1  rising-edge clock for all state.
REQ-008 SHALL: rst  input  1  synchronous active-high reset.
REQ-009 SHALL: i_coeff_write_en  input  1  write i_coeff_data to the shadow coefficient bank.
REQ-010 SHALL: i_coeff_addr  input  log2(TAPS)  shadow bank tap index.
REQ-011 SHALL: i_coeff_data  input  COEF_W  signed coefficient.
REQ-012 SHALL: i_coeff_commit  input  1  copy the shadow bank to the active bank.
REQ-013 SHALL: i_valid  input  1  i_data carries a new sample.
REQ-014 SHALL: i_data  input  DATA_W  signed sample.
REQ-015 SHALL: i_flush  input  1  clear the delay line and cancel in-flight results.
REQ-016 SHALL: o_valid  output  1  o_data carries a result this cycle.
REQ-017 SHALL: o_data  output  OUT_W  rounded, saturated filter output.
REQ-018 SHALL: o_sat  output  1  o_data was clamped; meaningful only with o_valid.

Function
REQ-019 SHALL: on i_valid, the sample enters tap 0 of the delay line and taps k-1 move to k; without i_valid the delay line holds.
REQ-020 SHALL: coefficient writes go only to the shadow bank, are accepted in any cycle including cycles with i_valid, and never alter an output.
REQ-021 SHALL: i_coeff_commit copies all shadow entries to the active bank in one edge; a write and a commit in the same cycle commit the newly written value.
REQ-022 SHALL: the products for a sample use the active bank as it stands on the edge after that sample is accepted; a commit in the same cycle as i_valid applies to that sample.
REQ-023 SHALL: pipeline stages are registered: delay line, product register, log2(TAPS) pairwise adder-tree levels, output stage; latency LAT = 3 + log2(TAPS) edges from the i_valid edge to o_valid (6 for TAPS=8).
REQ-024 SHALL: the pipeline never stalls; o_valid is i_valid delayed by exactly LAT cycles; back-to-back i_valid gives back-to-back o_valid.
REQ-025 SHALL: products are full precision (DATA_W+COEF_W); each tree level widens by 1 bit with sign extension, so no intermediate overflow occurs.
REQ-026 SHALL: output stage: when OUT_SHIFT>0 add 2^(OUT_SHIFT-1) (round half up); arithmetic shift right by OUT_SHIFT; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; o_sat=1 when clamping occurs.
REQ-027 SHALL: o_data and o_sat hold their last values while o_valid=0.
REQ-028 SHALL: i_flush zeroes the delay line and all valid-pipeline bits on the next edge and leaves both coefficient banks unchanged; i_flush with i_valid drops the sample; i_flush does not cancel a coefficient write or commit in the same cycle.
REQ-029 SHALL: priority is rst > i_flush > i_valid; coefficient operations are independent of i_valid and i_flush.

Reset
REQ-030 SHALL: on rst at a clk edge, clear the delay line, both coefficient banks, all pipeline registers and valid bits; o_valid=0, o_data=0, o_sat=0 from the next edge.
REQ-031 SHALL: rst mid-operation discards all in-flight results; no o_valid appears until LAT cycles after the first post-reset i_valid.

Verification
REQ-032 SHALL: impulse test: TAPS=8, OUT_SHIFT=0, write h[k]=k+1, commit, then input 1 followed by 7 zeros on consecutive cycles -> o_data 1,2,...,8 with o_valid starting 6 cycles after the first i_valid.
REQ-033 SHALL: saturation test: all h=-128, commit, drive i_data=-128 for 8 samples -> the 8th result is 32767 with o_sat=1; input 0 gives o_sat=0.
REQ-034 SHALL: rounding test: OUT_SHIFT=2, single tap set to 1, others 0, inputs 6 and -6 -> o_data 2 and -1.
REQ-035 SHALL: shadow/commit test: while streaming, write new shadow coefficients without commit -> outputs unchanged; then commit -> the sample accepted that cycle and all later samples use the new coefficients.
REQ-036 SHALL: flush/reset test: accept 3 samples, assert i_flush together with a 4th sample -> no o_valid for any of them, and the next impulse shows no residue; repeat with rst instead -> outputs 0 and coefficients 0 afterwards.

Source files
------------

// File: rtl/fir_pipelined_if.sv
// ---------------------------------------------------------------------------
// fir_pipelined_if
// Bundles the sample stream, coefficient-load and result signals of the
// pipelined FIR filter so the filter and its driver connect through one port.
//
// Signals (direction seen from the filter, i.e. the slave modport):
//   i_coeff_write_en  in   write i_coeff_data into the shadow coefficient bank
//   i_coeff_addr      in   shadow bank tap index, log2(TAPS) bits
//   i_coeff_data      in   signed coefficient, COEF_W bits
//   i_coeff_commit    in   copy the whole shadow bank into the active bank
//   i_valid           in   i_data carries a new sample
//   i_data            in   signed sample, DATA_W bits
//   i_flush           in   clear the delay line and cancel in-flight results
//   o_valid           out  o_data carries a result this cycle
//   o_data            out  rounded, saturated result, OUT_W bits
//   o_sat             out  o_data was clamped (meaningful with o_valid only)
//
// Modports: master drives the inputs (stimulus side), slave is the filter.
// ---------------------------------------------------------------------------
interface fir_pipelined_if #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16
);

  localparam int ADDR_W = $clog2(TAPS);

  logic                     i_coeff_write_en;
  logic [ADDR_W-1:0]        i_coeff_addr;
  logic signed [COEF_W-1:0] i_coeff_data;
  logic                     i_coeff_commit;
  logic                     i_valid;
  logic signed [DATA_W-1:0] i_data;
  logic                     i_flush;
  logic                     o_valid;
  logic signed [OUT_W-1:0]  o_data;
  logic                     o_sat;

  modport master (
    output i_coeff_write_en, i_coeff_addr, i_coeff_data, i_coeff_commit,
    output i_valid, i_data, i_flush,
    input  o_valid, o_data, o_sat
  );

  modport slave (
    input  i_coeff_write_en, i_coeff_addr, i_coeff_data, i_coeff_commit,
    input  i_valid, i_data, i_flush,
    output o_valid, o_data, o_sat
  );

endinterface

// File: rtl/fir_pipelined.sv
// ---------------------------------------------------------------------------
// fir_pipelined
// Fully pipelined, never-stalling direct-form FIR filter with a double
// buffered (shadow/active) coefficient bank.
//
// Pipeline: delay line -> product registers -> log2(TAPS) pairwise adder
// levels -> round/shift/saturate output register.  A sample presented with
// i_valid in cycle c produces o_valid in cycle c + 3 + log2(TAPS).
//
// Ports:
//   clk   in  rising-edge clock for all state
//   rst   in  synchronous active-high reset (clears data, banks and valids)
//   bus   fir_pipelined_if.slave  sample stream, coefficient load, results
//
// Parameters:
//   TAPS (power of two, 2..32), DATA_W, COEF_W, OUT_W, OUT_SHIFT
//   (arithmetic right shift applied, with round-half-up, before saturation).
// ---------------------------------------------------------------------------
module fir_pipelined #(
  parameter int TAPS      = 8,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic           clk,
  input  logic           rst,
  fir_pipelined_if.slave bus
);

  localparam int LOG_T  = $clog2(TAPS);
  localparam int ADDR_W = (LOG_T > 0) ? LOG_T : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + LOG_T;
  localparam int LAT    = 3 + LOG_T;
  localparam int RND_W  = SUM_W + 1;
  localparam int EXT_W  = ((RND_W > OUT_W) ? RND_W : OUT_W) + 1;
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  // The output stage works at EXT_W so that the rounding add can never wrap
  // and the clamp limits are representable regardless of OUT_W vs SUM_W.
  localparam logic signed [EXT_W-1:0] RND_V =
    (OUT_SHIFT > 0) ? (EXT_W'(1) <<< RND_SH) : '0;
  localparam logic signed [EXT_W-1:0] MAX_V =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [DATA_W-1:0] r_taps   [TAPS];
  logic signed [COEF_W-1:0] r_shadow [TAPS];
  logic signed [COEF_W-1:0] r_active [TAPS];
  logic signed [PROD_W-1:0] r_prod   [TAPS];
  logic [LAT-1:0]           r_valid;
  logic signed [OUT_W-1:0]  r_o_data;
  logic                     r_o_sat;

  logic signed [SUM_W-1:0]  w_sum;
  logic signed [EXT_W-1:0]  w_rounded;
  logic signed [EXT_W-1:0]  w_shifted;
  logic                     w_over;
  logic                     w_under;
  logic signed [OUT_W-1:0]  w_clamped;

  // Delay line: a new sample enters tap 0 and every tap moves one place
  // along; with no sample the line simply holds.  Flush empties the line so
  // nothing accepted before it can leak into later results.
  always_ff @(posedge clk) begin
    if (rst || bus.i_flush) begin
      for (int k = 0; k < TAPS; k++) r_taps[k] <= '0;
    end else if (bus.i_valid) begin
      r_taps[0] <= bus.i_data;
      for (int k = 1; k < TAPS; k++) r_taps[k] <= r_taps[k-1];
    end
  end

  // Coefficient banks: writes only ever land in the shadow bank, and a
  // commit copies the shadow bank to the active bank in a single edge.  A
  // write in the same cycle as a commit is forwarded straight into the
  // active bank so the freshly written value is the one committed.  Flush
  // and sample traffic deliberately have no influence here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      if (bus.i_coeff_write_en) begin
        r_shadow[bus.i_coeff_addr] <= bus.i_coeff_data;
      end
      if (bus.i_coeff_commit) begin
        for (int k = 0; k < TAPS; k++) begin
          if (bus.i_coeff_write_en && (bus.i_coeff_addr == ADDR_W'(k))) begin
            r_active[k] <= bus.i_coeff_data;
          end else begin
            r_active[k] <= r_shadow[k];
          end
        end
      end
    end
  end

  // Product stage: full-precision products of each tap with the active
  // coefficient as it stands one edge after the sample was accepted, which
  // is what makes a commit alongside i_valid apply to that very sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) r_prod[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        r_prod[k] <= PROD_W'(r_taps[k]) * PROD_W'(r_active[k]);
      end
    end
  end

  // Adder tree: each level halves the number of partial sums and grows the
  // word by one sign-extended bit, so no level can overflow.
  generate
    for (genvar l = 0; l < LOG_T; l++) begin : g_lvl
      localparam int NODES = TAPS >> (l + 1);
      localparam int IN_W  = PROD_W + l;

      logic signed [IN_W-1:0] w_in  [2*NODES];
      logic signed [IN_W:0]   r_sum [NODES];

      // The first level reads the product registers, later levels read the
      // partial sums of the level before them.
      if (l == 0) begin : g_src
        always_comb begin
          for (int j = 0; j < 2*NODES; j++) w_in[j] = r_prod[j];
        end
      end else begin : g_src
        always_comb begin
          for (int j = 0; j < 2*NODES; j++) w_in[j] = g_lvl[l-1].r_sum[j];
        end
      end

      // Pairwise registered sums for this level.
      always_ff @(posedge clk) begin
        for (int j = 0; j < NODES; j++) begin
          if (rst) begin
            r_sum[j] <= '0;
          end else begin
            r_sum[j] <= (IN_W+1)'(w_in[2*j]) + (IN_W+1)'(w_in[2*j+1]);
          end
        end
      end
    end
  endgenerate

  assign w_sum = g_lvl[LOG_T-1].r_sum[0];

  // Round half up, arithmetic shift, then clamp to the signed output range.
  assign w_rounded = EXT_W'(w_sum) + RND_V;
  assign w_shifted = w_rounded >>> OUT_SHIFT;
  assign w_over    = (w_shifted > MAX_V);
  assign w_under   = (w_shifted < MIN_V);
  assign w_clamped = w_over  ? MAX_V[OUT_W-1:0] :
                     w_under ? MIN_V[OUT_W-1:0] :
                               w_shifted[OUT_W-1:0];

  // Valid pipeline: one bit per register stage, shifting every cycle since
  // the filter never stalls.  Flush cancels everything in flight, and a
  // sample offered together with flush is dropped.
  always_ff @(posedge clk) begin
    if (rst || bus.i_flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= {r_valid[LAT-2:0], bus.i_valid};
    end
  end

  // Output register: only loaded when a live result reaches it, so o_data
  // and o_sat keep their last values between results and are not disturbed
  // by a result that a flush has just cancelled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_data <= '0;
      r_o_sat  <= 1'b0;
    end else if (r_valid[LAT-2] && !bus.i_flush) begin
      r_o_data <= w_clamped;
      r_o_sat  <= w_over || w_under;
    end
  end

  assign bus.o_valid = r_valid[LAT-1];
  assign bus.o_data  = r_o_data;
  assign bus.o_sat   = r_o_sat;

endmodule

// File: tb/tb_fir_pipelined.sv
// ---------------------------------------------------------------------------
// tb_fir_pipelined
// Scoreboard bench for fir_pipelined.  Two filters are instantiated: an
// 8-tap unshifted one for impulse, shadow/commit, flush, saturation and
// reset behaviour, and an 8-tap OUT_SHIFT=2 one for rounding.  Stimulus
// pushes hand-computed expected results into per-filter queues; monitors
// pop and compare whenever a filter raises o_valid, including the latency.
// ---------------------------------------------------------------------------
module tb_fir_pipelined;

  localparam int LAT = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cycleCount = 0;
  int vecCount   = 0;
  int missCount  = 0;

  typedef struct {
    logic signed [15:0] data;
    logic               sat;
    int                 cycle;
  } scoreEntry_t;

  scoreEntry_t q1[$];
  scoreEntry_t q2[$];
  scoreEntry_t e1;
  scoreEntry_t e2;

  fir_pipelined_if bus1 ();
  fir_pipelined_if bus2 ();

  fir_pipelined #(
    .TAPS(8), .DATA_W(8), .COEF_W(8), .OUT_W(16), .OUT_SHIFT(0)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  fir_pipelined #(
    .TAPS(8), .DATA_W(8), .COEF_W(8), .OUT_W(16), .OUT_SHIFT(2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Free-running clock and a cycle counter used to time-stamp stimulus.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Safety net so the run always ends even if the clock stops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one popped scoreboard entry against what the filter presented.
  task automatic checkOutput(input string name, input logic signed [15:0] gotData,
                             input logic gotSat, input int gotCycle,
                             input scoreEntry_t want);
    vecCount++;
    if (gotData !== want.data || gotSat !== want.sat ||
        (gotCycle - want.cycle) != LAT) begin
      missCount++;
      $display("[TB] FAIL %s: got data=%0d sat=%0b latency=%0d, required data=%0d sat=%0b latency=%0d",
               name, gotData, gotSat, gotCycle - want.cycle, want.data, want.sat, LAT);
    end
  endtask

  // Direct comparison of a sampled value against a constant.
  task automatic checkValue(input string name, input logic [31:0] got,
                            input logic [31:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Monitors: every o_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus1.o_valid === 1'b1) begin
      if (q1.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL fir8_unexpected_valid: got o_valid=1 data=%0d, required no result", bus1.o_data);
      end else begin
        e1 = q1.pop_front();
        checkOutput("fir8_result", bus1.o_data, bus1.o_sat, cycleCount, e1);
      end
    end
  end

  always @(negedge clk) begin
    if (bus2.o_valid === 1'b1) begin
      if (q2.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL round_unexpected_valid: got o_valid=1 data=%0d, required no result", bus2.o_data);
      end else begin
        e2 = q2.pop_front();
        checkOutput("round_result", bus2.o_data, bus2.o_sat, cycleCount, e2);
      end
    end
  end

  // One cycle of stimulus on the unshifted filter; optionally records the
  // expected result of the sample driven in this cycle.
  task automatic applyStimulus(input logic valid, input int data,
                               input logic we, input int addr, input int cdata,
                               input logic commit, input logic flush,
                               input logic doCheck, input int expData,
                               input logic expSat);
    bus1.i_valid          = valid;
    bus1.i_data           = 8'(data);
    bus1.i_coeff_write_en = we;
    bus1.i_coeff_addr     = 3'(addr);
    bus1.i_coeff_data     = 8'(cdata);
    bus1.i_coeff_commit   = commit;
    bus1.i_flush          = flush;
    if (doCheck) q1.push_back('{data: 16'(expData), sat: expSat, cycle: cycleCount});
    @(posedge clk);
    #1;
    bus1.i_valid          = 1'b0;
    bus1.i_coeff_write_en = 1'b0;
    bus1.i_coeff_commit   = 1'b0;
    bus1.i_flush          = 1'b0;
  endtask

  task automatic sampleCheck(input int data, input int expData, input logic expSat);
    applyStimulus(1'b1, data, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, expData, expSat);
  endtask

  task automatic sampleOnly(input int data);
    applyStimulus(1'b1, data, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic writeCoeff(input int addr, input int cdata);
    applyStimulus(1'b0, 0, 1'b1, addr, cdata, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic commitBank();
    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Let everything in flight come out before flushing, so no expectation
  // already in the queue is cancelled.
  task automatic drainAndFlush();
    idle(LAT + 2);
    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  // One sample on the rounding filter together with its expected result.
  task automatic roundStimulus(input int data, input int expData);
    bus2.i_valid = 1'b1;
    bus2.i_data  = 8'(data);
    q2.push_back('{data: 16'(expData), sat: 1'b0, cycle: cycleCount});
    @(posedge clk);
    #1;
    bus2.i_valid = 1'b0;
  endtask

  int rIn  [9] = '{6, -6, 5, 7, -7, -2, 2, -128, 127};
  int rExp [9] = '{2, -1, 1, 2, -2,  0, 1,  -32,  32};

  initial begin
    bus1.i_valid = 1'b0; bus1.i_data = '0; bus1.i_flush = 1'b0;
    bus1.i_coeff_write_en = 1'b0; bus1.i_coeff_addr = '0;
    bus1.i_coeff_data = '0; bus1.i_coeff_commit = 1'b0;
    bus2.i_valid = 1'b0; bus2.i_data = '0; bus2.i_flush = 1'b0;
    bus2.i_coeff_write_en = 1'b0; bus2.i_coeff_addr = '0;
    bus2.i_coeff_data = '0; bus2.i_coeff_commit = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkValue("reset_o_valid", 32'(bus1.o_valid), 0);
    checkValue("reset_o_data", 32'(bus1.o_data), 0);
    checkValue("reset_o_sat", 32'(bus1.o_sat), 0);
    checkValue("reset_round_o_valid", 32'(bus2.o_valid), 0);

    // Rounding: only tap 0 is non-zero, loaded by a write+commit in one cycle.
    $display("[TB] rounding with OUT_SHIFT=2");
    bus2.i_coeff_write_en = 1'b1;
    bus2.i_coeff_addr     = '0;
    bus2.i_coeff_data     = 8'sd1;
    bus2.i_coeff_commit   = 1'b1;
    @(posedge clk);
    #1;
    bus2.i_coeff_write_en = 1'b0;
    bus2.i_coeff_commit   = 1'b0;
    for (int i = 0; i < 9; i++) roundStimulus(rIn[i], rExp[i]);

    // Impulse: h[k] = k+1, response 1..8 on back-to-back cycles.
    $display("[TB] impulse response");
    for (int k = 0; k < 8; k++) writeCoeff(k, k + 1);
    commitBank();
    sampleCheck(1, 1, 1'b0);
    for (int k = 1; k < 8; k++) sampleCheck(0, k + 1, 1'b0);

    // Shadow writes while streaming ones leave results untouched until the
    // commit; the commit cycle also rewrites h[0]=5, giving [5,2,2,...].
    $display("[TB] shadow bank and commit");
    drainAndFlush();
    applyStimulus(1'b1, 1, 1'b1, 0, 2, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    applyStimulus(1'b1, 1, 1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    applyStimulus(1'b1, 1, 1'b1, 2, 2, 1'b0, 1'b0, 1'b1, 6, 1'b0);
    for (int k = 3; k < 8; k++) writeCoeff(k, 2);
    sampleCheck(1, 10, 1'b0);
    applyStimulus(1'b1, 1, 1'b1, 0, 5, 1'b1, 1'b0, 1'b1, 13, 1'b0);
    sampleCheck(1, 15, 1'b0);
    sampleCheck(1, 17, 1'b0);
    sampleCheck(1, 19, 1'b0);
    sampleCheck(1, 19, 1'b0);

    // Flush with three samples in flight and a fourth alongside it: none of
    // them may appear and the following impulse must show only [5,2,...].
    $display("[TB] flush");
    drainAndFlush();
    sampleOnly(9);
    sampleOnly(10);
    sampleOnly(11);
    applyStimulus(1'b1, 12, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(LAT + 2);
    sampleCheck(1, 5, 1'b0);
    for (int k = 1; k < 8; k++) sampleCheck(0, 2, 1'b0);

    // Saturation: all h=-128 and samples of -128 give 16384 per live tap.
    $display("[TB] saturation");
    for (int k = 0; k < 8; k++) writeCoeff(k, -128);
    commitBank();
    drainAndFlush();
    sampleCheck(-128, 16384, 1'b0);
    for (int k = 1; k < 8; k++) sampleCheck(-128, 32767, 1'b1);
    for (int k = 1; k <= 6; k++) sampleCheck(0, 32767, 1'b1);
    sampleCheck(0, 16384, 1'b0);
    sampleCheck(0, 0, 1'b0);
    sampleCheck(-128, 16384, 1'b0);

    // Reset mid-stream: in-flight results vanish, outputs and coefficients
    // return to zero.
    $display("[TB] reset mid-operation");
    idle(LAT + 2);
    sampleOnly(3);
    sampleOnly(4);
    sampleOnly(5);
    rst          = 1'b1;
    bus1.i_valid = 1'b1;
    bus1.i_data  = 8'sd6;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus1.i_valid = 1'b0;
    checkValue("midreset_o_valid", 32'(bus1.o_valid), 0);
    checkValue("midreset_o_data", 32'(bus1.o_data), 0);
    checkValue("midreset_o_sat", 32'(bus1.o_sat), 0);
    idle(LAT + 2);
    commitBank();
    sampleCheck(1, 0, 1'b0);
    sampleCheck(100, 0, 1'b0);
    sampleCheck(-128, 0, 1'b0);

    // Wait, bounded, for every outstanding expectation to be matched.
    for (int i = 0; i < 100 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge clk);
    idle(LAT + 2);
    checkValue("fir8_queue_drained", 32'(q1.size()), 0);
    checkValue("round_queue_drained", 32'(q2.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
